// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Summary  : Two-port arbiter for a single-port 64x8 data memory. Port A has
//            fixed priority, and a wait counter force-grants Port B.
//            Optional power-on clear of the memory via macro DMEM_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE     = 2'd1;
  localparam logic [1:0] S_ISSUE    = 2'd2;
`ifdef DMEM_CLEAR_EN
  localparam logic [1:0] S_INIT     = 2'd0;
  localparam logic [1:0] S_RESET    = S_INIT;
`else
  localparam logic [1:0] S_RESET    = S_IDLE;
`endif
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [1:0]        state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q,         we_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic [3:0]        b_wait_cnt_q, b_wait_cnt_d;
  logic [DATA_W-1:0] a_rdata_q,    a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q,    b_rdata_d;
  logic              a_rvalid_q,   a_rvalid_d;
  logic              b_rvalid_q,   b_rvalid_d;
`ifdef DMEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt_q,    clr_cnt_d;
`endif
  logic              b_wins;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RESET;
      last_grant_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      b_wait_cnt_q <= 4'd0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
`ifdef DMEM_CLEAR_EN
      clr_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      b_wait_cnt_q <= b_wait_cnt_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
`ifdef DMEM_CLEAR_EN
      clr_cnt_q    <= clr_cnt_d;
`endif
    end
  end

  // Next-state and datapath latch logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    b_wait_cnt_d = b_wait_cnt_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    a_rvalid_d   = 1'b0;
    b_rvalid_d   = 1'b0;
`ifdef DMEM_CLEAR_EN
    clr_cnt_d    = clr_cnt_q;
`endif
    b_wins       = b_req && (!a_req || (b_wait_cnt_q == WAIT_LIMIT));

    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          state_d      = S_ISSUE;
          last_grant_d = b_wins;
          we_d         = b_wins ? b_we    : a_we;
          addr_d       = b_wins ? b_addr  : a_addr;
          wdata_d      = b_wins ? b_wdata : a_wdata;
        end
        // B lost to A this arbitration: age the pending request
        if (b_req && !b_wins) begin
          b_wait_cnt_d = (b_wait_cnt_q == WAIT_LIMIT) ? b_wait_cnt_q
                                                      : b_wait_cnt_q + 4'd1;
        end else begin
          b_wait_cnt_d = 4'd0;
        end
      end
      S_ISSUE: begin
        state_d = S_IDLE;
        if (!we_q) begin
          if (last_grant_q) begin
            b_rdata_d  = mem_rdata;
            b_rvalid_d = 1'b1;
          end else begin
            a_rdata_d  = mem_rdata;
            a_rvalid_d = 1'b1;
          end
        end
      end
`ifdef DMEM_CLEAR_EN
      S_INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_RESET;
    endcase
  end

  // Output decode
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        a_ack     = !last_grant_q;
        b_ack     = last_grant_q;
      end
`ifdef DMEM_CLEAR_EN
      S_INIT: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = clr_cnt_q;
        busy     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Summary  : Directed self-checking bench for dmem_arbiter with a behavioural
//            64x8 memory. Honours DMEM_CLEAR_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

`ifdef DMEM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we;
  logic [5:0] a_addr, b_addr, mem_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic       a_ack, a_rvalid, b_ack, b_rvalid;
  logic       mem_en, mem_we, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [64];
  bit         mem_init = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(6), .DATA_W(8), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Preload pattern; a completed clear leaves every line at zero
  function automatic logic [7:0] init_val(input int i);
    return CLR ? 8'h00 : (8'(i) ^ 8'h5A);
  endfunction

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    // A write held from reset onwards
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'h05; a_wdata = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_en",   mem_en,   CLR);
    check("rst_busy",     busy,     CLR);
    check("rst_a_ack",    a_ack,    0);
    check("rst_b_ack",    b_ack,    0);
    check("rst_a_rvalid", a_rvalid, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;

`ifdef DMEM_CLEAR_EN
    begin
      int errs = 0;
      for (int k = 0; k < 64; k++) begin
        if (!(busy && mem_en && mem_we && mem_addr == 6'(k) && mem_wdata == 8'h00 && !a_ack))
          errs++;
        tick();
      end
      check("clr_walk_errs", errs, 0);
      check("clr_busy_low",  busy, 0);
      check("clr_idle_ack",  a_ack, 0);
    end
`endif
    tick();

    // A write then read back
    check("t1_a_ack",     a_ack,     1);
    check("t1_b_ack",     b_ack,     0);
    check("t1_mem_en",    mem_en,    1);
    check("t1_mem_we",    mem_we,    1);
    check("t1_mem_addr",  mem_addr,  6'h05);
    check("t1_mem_wdata", mem_wdata, 8'hA5);
    a_req = 1'b0;
    tick();
    check("t1_idle_en",   mem_en,   0);
    check("t1_idle_addr", mem_addr, 0);
    check("t1_wr_rvalid", a_rvalid, 0);
    a_req = 1'b1; a_we = 1'b0; a_wdata = 8'h00;
    tick();
    check("t1_rd_ack", a_ack,  1);
    check("t1_rd_we",  mem_we, 0);
    a_req = 1'b0;
    tick();
    check("t1_rvalid", a_rvalid, 1);
    check("t1_rdata",  a_rdata,  8'hA5);
    tick();
    check("t1_rvalid_pulse", a_rvalid, 0);
    check("t1_rdata_hold",   a_rdata,  8'hA5);

    // Simultaneous requests: A first, B on the next arbitration
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'h01;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'h02;
    tick();
    check("t2_a_ack",  a_ack,    1);
    check("t2_b_wait", b_ack,    0);
    check("t2_addr_a", mem_addr, 6'h01);
    a_req = 1'b0;
    tick();
    check("t2_a_rvalid", a_rvalid, 1);
    check("t2_a_rdata",  a_rdata,  init_val(1));
    tick();
    check("t2_b_ack",  b_ack,    1);
    check("t2_addr_b", mem_addr, 6'h02);
    b_req = 1'b0;
    tick();
    check("t2_b_rvalid", b_rvalid, 1);
    check("t2_b_rdata",  b_rdata,  init_val(2));

    // Starvation: B force-granted on the 5th arbitration
    a_req = 1'b1; a_we = 1'b1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'h09;
    for (int k = 1; k <= 5; k++) begin
      a_addr = 6'(16 + k); a_wdata = 8'(k);
      tick();
      check($sformatf("t3_a_ack_%0d", k), a_ack, (k < 5));
      check($sformatf("t3_b_ack_%0d", k), b_ack, (k == 5));
      if (k == 5) begin
        a_req = 1'b0; b_req = 1'b0;
        check("t3_wait_clr", dut.b_wait_cnt_q, 0);
      end
      tick();
    end
    check("t3_b_rvalid", b_rvalid, 1);
    check("t3_b_rdata",  b_rdata,  init_val(9));

    // Reset during the ISSUE cycle of a B read
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'h3F;
    tick();
    check("t4_b_ack", b_ack,    1);
    check("t4_addr",  mem_addr, 6'h3F);
    reset = 1'b1; b_req = 1'b0;
    tick();
    check("t4_mem_en",   mem_en,   CLR);
    check("t4_busy",     busy,     CLR);
    check("t4_b_ack",    b_ack,    0);
    check("t4_b_rvalid", b_rvalid, 0);
    check("t4_b_rdata",  b_rdata,  0);
    check("t4_a_rdata",  a_rdata,  0);
    reset = 1'b0;
`ifdef DMEM_CLEAR_EN
    begin
      int guard = 0;
      while (busy && guard < 200) begin
        tick();
        guard++;
      end
      check("t4_clear_done", busy, 0);
    end
`endif
    tick();
    check("t4_no_rvalid", b_rvalid, 0);

    // Collision at top address, then line 0 via B
    a_req = 1'b1; a_we = 1'b1; a_addr = 6'h3F; a_wdata = 8'h3C;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'h3F;
    tick();
    check("t5_a_ack",   a_ack,     1);
    check("t5_a_addr",  mem_addr,  6'h3F);
    check("t5_a_wdata", mem_wdata, 8'h3C);
    a_req = 1'b0;
    tick();
    tick();
    check("t5_b_ack",  b_ack,    1);
    check("t5_b_addr", mem_addr, 6'h3F);
    b_req = 1'b0;
    tick();
    check("t5_b_rvalid", b_rvalid, 1);
    check("t5_b_rdata",  b_rdata,  8'h3C);
    b_req = 1'b1; b_we = 1'b1; b_addr = 6'h00; b_wdata = 8'h77;
    tick();
    check("t5_b0_ack",   b_ack,     1);
    check("t5_b0_addr",  mem_addr,  6'h00);
    check("t5_b0_we",    mem_we,    1);
    check("t5_b0_wdata", mem_wdata, 8'h77);
    b_req = 1'b0;
    tick();
    check("t5_b0_wr_rvalid", b_rvalid, 0);
    check("t5_b_rdata_hold", b_rdata,  8'h3C);
    b_req = 1'b1; b_we = 1'b0;
    tick();
    b_req = 1'b0;
    tick();
    check("t5_b0_rvalid", b_rvalid, 1);
    check("t5_b0_rdata",  b_rdata,  8'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
